// File: rtl/enc_event_packer.sv
// Event packer: buffers edge events in a FWFT FIFO and emits 64-bit records on AXI4-Stream with tlast framing.
// Optional `ENC_PACK_DROP_CNT_EN` adds a saturating 32-bit drop_count output.
module enc_event_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_LEN    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
`ifdef ENC_PACK_DROP_CNT_EN
    output logic [31:0] drop_count,
`endif
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Handshakes: a beat transfers on any cycle with tvalid && tready. The master
    // side holds tdata/tlast/tvalid while tvalid && !tready. The slave side never
    // stalls; tready is low only during reset and losses are flagged in-band.

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   beat_cnt;
    logic          flush_pend;
    logic          loss_pend;
    logic          last_hold;

    logic          full;
    logic          empty;
    logic          wr_en;
    logic          drop;
    logic          rd_en;
    logic          beat_last;
    logic          flush_set;
    logic          unused_inputs;

    assign unused_inputs = ^{s_axis_tlast, s_axis_tdata[63:62]};

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign wr_en     = s_axis_tvalid && enable && !full;
    assign drop      = s_axis_tvalid && enable && full;
    assign rd_en     = m_axis_tvalid && m_axis_tready;
    assign beat_last = (beat_cnt == 16'(PKT_LEN - 1));
    assign flush_set = flush && !flush_pend && !(beat_cnt == '0 && empty);

    assign s_axis_tready = !rst;
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? 64'd0 : mem[rd_ptr];
    // last_hold keeps a presented tlast from being retracted when a write lands during a stall
    assign m_axis_tlast  = !empty && (last_hold || beat_last ||
                                      (flush_pend && count == CW'(1)));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tuser, loss_pend, s_axis_tdata[61:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            last_hold  <= 1'b0;
        end else begin
            if (rd_en) beat_cnt <= m_axis_tlast ? 16'd0 : beat_cnt + 16'd1;

            if (flush_set)                  flush_pend <= 1'b1;
            else if (rd_en && m_axis_tlast) flush_pend <= 1'b0;

            if (rd_en)                              last_hold <= 1'b0;
            else if (m_axis_tvalid && m_axis_tlast) last_hold <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_pend <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (drop) begin
                loss_pend <= 1'b1;
                overflow  <= 1'b1;
            end else if (wr_en) begin
                loss_pend <= 1'b0;
            end
        end
    end

`ifdef ENC_PACK_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && drop_count != 32'hFFFF_FFFF) begin
            drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_enc_event_packer.sv
// Testbench for enc_event_packer: cycle-stepped driver, expected-record queue scoreboard, final report.
// Checks drop_count only when built with ENC_PACK_DROP_CNT_EN.
module tb_enc_event_packer;

  localparam int DEPTH = 16;
  localparam int PKT   = 4;
  localparam int W     = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        overflow;
`ifdef ENC_PACK_DROP_CNT_EN
  logic [31:0] drop_count;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  enc_event_packer #(.FIFO_DEPTH(DEPTH), .PKT_LEN(PKT)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .flush         (flush),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
`ifdef ENC_PACK_DROP_CNT_EN
    .drop_count    (drop_count),
`endif
    .overflow      (overflow)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W:0]   out_q[$];
  int           m_beat;
  bit           m_fp, m_lp, m_ov, m_prev_stall, m_prev_last;
  logic [31:0]  m_drops;
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_beat = 0; m_fp = 0; m_lp = 0; m_ov = 0;
    m_prev_stall = 0; m_prev_last = 0; m_drops = '0;
  endtask

  // driver: one clock cycle; entered and left at posedge+1
  task automatic step(input bit v, input logic [63:0] d, input bit u, input bit rdy,
                      input bit fl, input bit en, input bit r);
    int n;
    bit exp_last, hs, fset;
    rst = r; s_axis_tvalid = v; s_axis_tdata = d; s_axis_tuser = u;
    m_axis_tready = rdy; flush = fl; enable = en; s_axis_tlast = $urandom_range(0, 1);
    @(negedge clk);
    n = exp_q.size();
    exp_last = (m_beat == PKT - 1) || (m_fp && n == 1) || (m_prev_stall && m_prev_last);
    check("s_tready", 64'(s_axis_tready), 64'(!r));
    check("m_tvalid", 64'(m_axis_tvalid), 64'(n != 0));
    if (n != 0) begin
      check("m_tdata", m_axis_tdata, exp_q[0]);
      check("m_tlast", 64'(m_axis_tlast), 64'(exp_last));
    end
    check("overflow", 64'(overflow), 64'(m_ov));
`ifdef ENC_PACK_DROP_CNT_EN
    check("drop_count", 64'(drop_count), 64'(m_drops));
`endif
    hs = (n != 0) && rdy;
    if (hs) out_q.push_back({m_axis_tlast, m_axis_tdata});
    if (r) begin
      model_clear();
    end else begin
      fset = fl && !m_fp && !(m_beat == 0 && n == 0);
      if (hs) begin
        void'(exp_q.pop_front());
        m_beat = exp_last ? 0 : m_beat + 1;
      end
      if (fset) m_fp = 1;
      else if (hs && exp_last) m_fp = 0;
      if (v && en) begin
        if (n < DEPTH) begin
          exp_q.push_back({u, m_lp, d[61:0]});
          m_lp = 0;
        end else begin
          m_lp = 1; m_ov = 1;
          if (m_drops != 32'hFFFF_FFFF) m_drops++;
        end
      end
      m_prev_stall = (n != 0) && !rdy;
      m_prev_last  = exp_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [63:0] d, input bit u, input bit rdy);
    step(1, d, u, rdy, 0, 1, 0);
  endtask

  task automatic idle(input int cycles, input bit rdy);
    for (int i = 0; i < cycles; i++) step(0, 64'd0, 0, rdy, 0, 1, 0);
  endtask

  task automatic do_reset();
    step(0, 64'd0, 0, 0, 0, 1, 1);
    out_q.delete();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      idle(1, 1);
      k++;
    end
    check("drain_budget", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int nev;
    int losses;
    rst = 1; enable = 1; flush = 0; s_axis_tdata = '0; s_axis_tuser = 0;
    s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
`ifdef ENC_PACK_DROP_CNT_EN
    check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    @(posedge clk);
    #1;

    // three basic records, one cycle latency each
    ev(64'h10, 1, 1); ev(64'h20, 0, 1); ev(64'h30, 1, 1);
    idle(3, 1);
    check("t1_count", 64'(out_q.size()), 64'd3);
    if (out_q.size() == 3) begin
      check("t1_rec0", out_q[0], {1'b0, 64'h8000_0000_0000_0010});
      check("t1_rec1", out_q[1], {1'b0, 64'h0000_0000_0000_0020});
      check("t1_rec2", out_q[2], {1'b0, 64'h8000_0000_0000_0030});
    end

    // full-rate packets of PKT records: tlast on 4th and 8th
    do_reset();
    for (int i = 0; i < 9; i++) ev(64'h100 + 64'(i), i[0], 1);
    idle(3, 1);
    check("t2_count", 64'(out_q.size()), 64'd9);
    for (int i = 0; i < out_q.size(); i++)
      check("t2_tlast", 64'(out_q[i][64]), 64'(i == 3 || i == 7));

    // overflow: 20 events into a stalled 16-deep FIFO
    do_reset();
    for (int i = 0; i < 20; i++) ev({2'b11, 62'h200 + 62'(i)}, i[0], 0);
    check("t3_overflow", 64'(overflow), 64'd1);
`ifdef ENC_PACK_DROP_CNT_EN
    check("t3_drop_count", 64'(drop_count), 64'd4);
`endif
    drain(40);
    check("t3_count", 64'(out_q.size()), 64'd16);
    for (int i = 0; i < out_q.size(); i++)
      check("t3_rec", out_q[i][63:0], {1'(i[0]), 1'b0, 62'h200 + 62'(i)});
    ev(64'h300, 0, 1); ev(64'h301, 0, 1);
    idle(3, 1);
    check("t3_count2", 64'(out_q.size()), 64'd18);
    if (out_q.size() == 18) begin
      check("t3_loss_set", 64'(out_q[16][62]), 64'd1);
      check("t3_loss_clr", 64'(out_q[17][62]), 64'd0);
    end

    // reset mid-packet with 7 buffered records; overflow still set from above
    for (int i = 0; i < 7; i++) ev(64'h400 + 64'(i), 0, 0);
    do_reset();
    check("t4_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t4_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) ev(64'h500 + 64'(i), 1, 1);
    idle(3, 1);
    check("t4_count", 64'(out_q.size()), 64'd4);
    for (int i = 0; i < out_q.size(); i++)
      check("t4_tlast", 64'(out_q[i][64]), 64'(i == 3));

    // flush while a record is stalled; then ignored flush on empty/beat 0
    do_reset();
    ev(64'h600, 0, 1); ev(64'h601, 0, 0); ev(64'h602, 0, 0);
    step(0, 64'd0, 0, 0, 1, 1, 0);
    idle(2, 0);
    drain(10);
    step(0, 64'd0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) ev(64'h700 + 64'(i), 0, 1);
    idle(3, 1);
    check("t5_count", 64'(out_q.size()), 64'd7);
    for (int i = 0; i < out_q.size(); i++)
      check("t5_tlast", 64'(out_q[i][64]), 64'(i == 2 || i == 6));

    // flush with sole occupant stalled, then a write: tlast must not retract
    do_reset();
    ev(64'h800, 1, 0);
    step(0, 64'd0, 0, 0, 1, 1, 0);
    ev(64'h801, 0, 0);
    idle(1, 0);
    drain(10);
    step(1, 64'h802, 0, 1, 0, 0, 0);
    idle(2, 1);
    check("t6_count", 64'(out_q.size()), 64'd2);
    if (out_q.size() == 2) begin
      check("t6_rec0", out_q[0], {1'b1, 64'h8000_0000_0000_0800});
      check("t6_rec1", out_q[1], {1'b0, 64'h0000_0000_0000_0801});
    end
    check("t6_no_loss", 64'(overflow), 64'd0);

    // random backpressure, 50% input density, occasional flush
    do_reset();
    nev = 0;
    while (nev < 10000) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      step(v, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, 1, 0);
      if (v) nev++;
    end
    drain(100);
    check("t7_count", 64'(out_q.size()), 64'(nev));
    losses = 0;
    foreach (out_q[i]) if (out_q[i][62]) losses++;
    check("t7_losses", 64'(losses), 64'd0);
    check("t7_overflow", 64'(overflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
